// File: rtl/cardinal_router_node_xy_p_if.sv
// Single-channel valid/ready flit link (v = valid, d = flit, r = ready).
// The master drives v/d and the slave drives r.
interface cardinal_router_node_xy_p_if #(
  parameter int unsigned DATA_W = 64
);
  logic              v;
  logic [DATA_W-1:0] d;
  logic              r;

  modport master (output v, output d, input  r);
  modport slave  (input  v, input  d, output r);
endinterface

// File: rtl/cardinal_router_node_xy_p.sv
// Five-port XY mesh router node: per-input FIFOs, per-output round-robin arbiters, registered egress.
// Optional macro CARDINAL_ROUTER_STATS_EN adds per-output delivered-flit counters on pkt_cnt.
module cardinal_router_node_xy_p #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned X_W    = 4,
  parameter int unsigned Y_W    = 4,
  parameter int unsigned X_LSB  = 0,
  parameter int unsigned Y_LSB  = 8,
  parameter int unsigned MY_X   = 0,
  parameter int unsigned MY_Y   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              n_si, s_si, e_si, w_si, pe_si,
  input  logic [DATA_W-1:0] n_di, s_di, e_di, w_di, pe_di,
  output logic              n_ri, s_ri, e_ri, w_ri, pe_ri,
  output logic              n_so, s_so, e_so, w_so, pe_so,
  output logic [DATA_W-1:0] n_do, s_do, e_do, w_do, pe_do,
  input  logic              n_ro, s_ro, e_ro, w_ro, pe_ro,
  output logic              polarity
`ifdef CARDINAL_ROUTER_STATS_EN
  ,
  output logic [5*32-1:0]   pkt_cnt
`endif
);
  typedef enum logic [2:0] {DIR_N = 3'd0, DIR_S, DIR_E, DIR_W, DIR_PE} dir_e;

  localparam int unsigned NCH = 5;
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);

  logic [NCH-1:0]    si, ri, ro, push, pop, full, nempty;
  logic [NCH-1:0]    so_q, so_d;
  logic [DATA_W-1:0] di [NCH];
  logic [DATA_W-1:0] head [NCH];
  logic [DATA_W-1:0] do_q [NCH];
  logic [DATA_W-1:0] do_d [NCH];
  logic [DATA_W-1:0] mem_q [NCH][DEPTH];
  logic [PW-1:0]     rdp_q [NCH];
  logic [PW-1:0]     wrp_q [NCH];
  logic [CW-1:0]     cnt_q [NCH];
  logic [2:0]        rr_q [NCH];
  logic [2:0]        rr_d [NCH];
  dir_e              route [NCH];
  logic              polarity_q;

  assign si    = {pe_si, w_si, e_si, s_si, n_si};
  assign ro    = {pe_ro, w_ro, e_ro, s_ro, n_ro};
  assign di[0] = n_di;
  assign di[1] = s_di;
  assign di[2] = e_di;
  assign di[3] = w_di;
  assign di[4] = pe_di;
  assign {pe_ri, w_ri, e_ri, s_ri, n_ri} = ri;
  assign {pe_so, w_so, e_so, s_so, n_so} = so_q;
  assign n_do     = do_q[0];
  assign s_do     = do_q[1];
  assign e_do     = do_q[2];
  assign w_do     = do_q[3];
  assign pe_do    = do_q[4];
  assign polarity = polarity_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // FIFO status and XY route of every head
  always_comb begin
    logic [31:0] dx, dy;
    dx = '0;
    dy = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      full[i]   = (cnt_q[i] == CW'(DEPTH));
      nempty[i] = (cnt_q[i] != '0);
      ri[i]     = reset && !full[i];
      push[i]   = si[i] && ri[i];
      head[i]   = mem_q[i][rdp_q[i]];
      dx        = 32'(head[i][X_LSB +: X_W]);
      dy        = 32'(head[i][Y_LSB +: Y_W]);
      if (dx > MY_X)      route[i] = DIR_E;
      else if (dx < MY_X) route[i] = DIR_W;
      else if (dy > MY_Y) route[i] = DIR_S;
      else if (dy < MY_Y) route[i] = DIR_N;
      else                route[i] = DIR_PE;
    end
  end

  // Each head routes to exactly one output, so one grant per input falls out naturally
  always_comb begin
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    pop   = '0;
    so_d  = so_q;
    for (int unsigned j = 0; j < NCH; j++) begin
      do_d[j] = do_q[j];
      rr_d[j] = rr_q[j];
      if (so_q[j] && ro[j]) so_d[j] = 1'b0;
      found = 1'b0;
      if (!so_q[j] || ro[j]) begin
        for (int unsigned k = 0; k < NCH; k++) begin
          idx = (32'(rr_q[j]) + k) % NCH;
          if (!found && nempty[idx] && route[idx] == dir_e'(3'(j))) begin
            found     = 1'b1;
            pop[idx]  = 1'b1;
            so_d[j]   = 1'b1;
            do_d[j]   = head[idx];
            rr_d[j]   = 3'((idx + 1) % NCH);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      so_q       <= '0;
      polarity_q <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        do_q[i]  <= '0;
        rr_q[i]  <= '0;
        rdp_q[i] <= '0;
        wrp_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      so_q       <= so_d;
      polarity_q <= !polarity_q;
      for (int unsigned i = 0; i < NCH; i++) begin
        do_q[i] <= do_d[i];
        rr_q[i] <= rr_d[i];
        if (push[i]) wrp_q[i] <= ptr_inc(wrp_q[i]);
        if (pop[i])  rdp_q[i] <= ptr_inc(rdp_q[i]);
        cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  // Storage needs no reset: occupancy counters alone define validity
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NCH; i++) begin
      if (push[i]) mem_q[i][wrp_q[i]] <= di[i];
    end
  end

`ifdef CARDINAL_ROUTER_STATS_EN
  logic [31:0] pkt_q [NCH];

  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < NCH; j++) begin
      if (!reset)                 pkt_q[j] <= '0;
      else if (so_q[j] && ro[j])  pkt_q[j] <= pkt_q[j] + 32'd1;
    end
  end

  always_comb begin
    pkt_cnt = '0;
    for (int unsigned j = 0; j < NCH; j++) pkt_cnt[32*j +: 32] = pkt_q[j];
  end
`endif
endmodule

// File: tb/tb_cardinal_router_node_xy_p.sv
// Scoreboard bench for cardinal_router_node_xy_p (MY_X=1, MY_Y=1): directed routing/latency,
// round-robin, backpressure and mid-run reset checks, then randomized traffic.
module tb_cardinal_router_node_xy_p;
  localparam int unsigned DW = 32;

  typedef struct {
    int            dst;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [4:0]    si, ro, ri, so;
  logic [DW-1:0] di [5];
  logic [DW-1:0] dout [5];
  logic          polarity;
`ifdef CARDINAL_ROUTER_STATS_EN
  logic [5*32-1:0] pkt_cnt;
`endif

  int total = 0;
  int bad = 0;
  int seq = 0;
  int acc_cnt = 0;
  int deliv [5];
  bit mon_en = 1'b0;
  bit hold_v [5];
  logic [DW-1:0] hold_d [5];
  exp_t exq [$];
  logic [2:0] e_log [$];

  cardinal_router_node_xy_p_if #(.DATA_W(DW)) ig_n (), ig_s (), ig_e (), ig_w (), ig_pe ();
  cardinal_router_node_xy_p_if #(.DATA_W(DW)) eg_n (), eg_s (), eg_e (), eg_w (), eg_pe ();

  assign ig_n.v = si[0];  assign ig_n.d = di[0];  assign ri[0] = ig_n.r;
  assign ig_s.v = si[1];  assign ig_s.d = di[1];  assign ri[1] = ig_s.r;
  assign ig_e.v = si[2];  assign ig_e.d = di[2];  assign ri[2] = ig_e.r;
  assign ig_w.v = si[3];  assign ig_w.d = di[3];  assign ri[3] = ig_w.r;
  assign ig_pe.v = si[4]; assign ig_pe.d = di[4]; assign ri[4] = ig_pe.r;
  assign eg_n.r = ro[0];  assign so[0] = eg_n.v;  assign dout[0] = eg_n.d;
  assign eg_s.r = ro[1];  assign so[1] = eg_s.v;  assign dout[1] = eg_s.d;
  assign eg_e.r = ro[2];  assign so[2] = eg_e.v;  assign dout[2] = eg_e.d;
  assign eg_w.r = ro[3];  assign so[3] = eg_w.v;  assign dout[3] = eg_w.d;
  assign eg_pe.r = ro[4]; assign so[4] = eg_pe.v; assign dout[4] = eg_pe.d;

  cardinal_router_node_xy_p #(
    .DATA_W(DW), .DEPTH(2), .X_W(4), .Y_W(4), .X_LSB(0), .Y_LSB(8), .MY_X(1), .MY_Y(1)
  ) dut (
    .clk(clk), .reset(reset),
    .n_si(ig_n.v), .s_si(ig_s.v), .e_si(ig_e.v), .w_si(ig_w.v), .pe_si(ig_pe.v),
    .n_di(ig_n.d), .s_di(ig_s.d), .e_di(ig_e.d), .w_di(ig_w.d), .pe_di(ig_pe.d),
    .n_ri(ig_n.r), .s_ri(ig_s.r), .e_ri(ig_e.r), .w_ri(ig_w.r), .pe_ri(ig_pe.r),
    .n_so(eg_n.v), .s_so(eg_s.v), .e_so(eg_e.v), .w_so(eg_w.v), .pe_so(eg_pe.v),
    .n_do(eg_n.d), .s_do(eg_s.d), .e_do(eg_e.d), .w_do(eg_w.d), .pe_do(eg_pe.d),
    .n_ro(eg_n.r), .s_ro(eg_s.r), .e_ro(eg_e.r), .w_ro(eg_w.r), .pe_ro(eg_pe.r),
    .polarity(polarity)
`ifdef CARDINAL_ROUTER_STATS_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );

  // Flit layout: [3:0] dx, [7:4] filler, [11:8] dy, [14:12] source port, [31:16] sequence
  function automatic logic [DW-1:0] mkflit(input int src, input logic [3:0] dx, input logic [3:0] dy,
                                            input int s);
    logic [3:0] r;
    logic [2:0] sp;
    logic [15:0] sq;
    r  = 4'($urandom_range(0, 15));
    sp = 3'(src);
    sq = 16'(s);
    return {sq, 1'b0, sp, dy, r, dx};
  endfunction

  // Reference XY decision for a node at (1,1): 0=N 1=S 2=E 3=W 4=PE
  function automatic int ref_route(input logic [DW-1:0] f);
    int dx, dy;
    dx = int'(f[3:0]);
    dy = int'(f[11:8]);
    if (dx > 1) return 2;
    if (dx < 1) return 3;
    if (dy > 1) return 1;
    if (dy < 1) return 0;
    return 4;
  endfunction

  function automatic int rr_next(input int p);
    case (p)
      0: return 1;
      1: return 3;
      3: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string nm, input longint got, input longint expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, expv);
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  // Monitor: every egress transfer must match the oldest outstanding flit of that source->output pair
  always @(negedge clk) begin
    if (!mon_en) begin
      for (int j = 0; j < 5; j++) hold_v[j] = 1'b0;
    end else begin
      for (int j = 0; j < 5; j++) begin
        if (hold_v[j]) begin
          chk("hold_so", longint'(so[j]), 1);
          chk("hold_do", longint'(dout[j]), longint'(hold_d[j]));
        end
        hold_v[j] = so[j] && !ro[j];
        hold_d[j] = dout[j];
        if (so[j] && ro[j]) begin
          int idx;
          idx = -1;
          deliv[j]++;
          if (j == 2) e_log.push_back(dout[j][14:12]);
          for (int n = 0; n < exq.size(); n++)
            if (idx < 0 && exq[n].dst == j && exq[n].data[14:12] == dout[j][14:12]) idx = n;
          if (idx < 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected out=%0d got=%h exp=none", j, dout[j]);
          end else begin
            chk("sb_data", longint'(dout[j]), longint'(exq[idx].data));
            exq.delete(idx);
          end
        end
      end
    end
  end

  // Per cycle: record accepted flits, then offer new ones on masked channels
  task automatic drive(input int n, input logic [4:0] mask, input bit e_only, input bit rand_ro,
                       input logic [4:0] ro_fixed);
    bit acc [5];
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int ch = 0; ch < 5; ch++) begin
        acc[ch] = 1'b0;
        if (si[ch] && ri[ch]) begin
          exq.push_back('{dst: ref_route(di[ch]), data: di[ch]});
          acc[ch] = 1'b1;
          acc_cnt++;
        end
      end
      @(posedge clk);
      #1;
      for (int ch = 0; ch < 5; ch++) begin
        if (!si[ch] || acc[ch]) begin
          if (mask[ch] && (e_only || $urandom_range(0, 2) != 0)) begin
            si[ch] = 1'b1;
            di[ch] = mkflit(ch, e_only ? 4'd3 : 4'($urandom_range(0, 3)),
                            4'($urandom_range(0, 3)), seq);
            seq++;
          end else si[ch] = 1'b0;
        end
        ro[ch] = rand_ro ? ($urandom_range(0, 3) != 0) : ro_fixed[ch];
      end
    end
    si = '0;
  endtask

  task automatic drain();
    si = '0;
    ro = '1;
    for (int c = 0; c < 200 && exq.size() != 0; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    at_neg();
    chk("drain_left", exq.size(), 0);
  endtask

  task automatic one_flit(input int ch, input logic [3:0] dx, input logic [3:0] dy, input int dst,
                          input string nm);
    logic [DW-1:0] f;
    @(posedge clk);
    #1;
    f = mkflit(ch, dx, dy, seq);
    seq++;
    si[ch] = 1'b1;
    di[ch] = f;
    exq.push_back('{dst: ref_route(f), data: f});
    @(posedge clk);
    #1;
    si[ch] = 1'b0;
    at_neg();
    chk({nm, "_early"}, so, 0);
    @(posedge clk);
    at_neg();
    chk({nm, "_so"}, so, longint'(1) << dst);
    chk({nm, "_do"}, dout[dst], f);
    @(posedge clk);
    at_neg();
    chk({nm, "_gone"}, so, 0);
  endtask

  initial begin
    reset = 1'b0;
    si = '0;
    ro = '1;
    for (int ch = 0; ch < 5; ch++) begin
      di[ch] = '0;
      deliv[ch] = 0;
    end
    repeat (2) @(posedge clk);
    at_neg();
    chk("rst_ri", ri, 0);
    chk("rst_so", so, 0);
    chk("rst_do", dout[0] | dout[1] | dout[2] | dout[3] | dout[4], 0);
    chk("rst_pol", polarity, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    mon_en = 1'b1;
    at_neg();
    chk("pol_first", polarity, 0);
    chk("ri_up", ri, 5'h1f);
    at_neg();
    chk("pol_toggle", polarity, 1);

    one_flit(4, 4'd3, 4'd1, 2, "pe_to_e");
    one_flit(3, 4'd1, 4'd0, 0, "w_to_n");
    one_flit(0, 4'd1, 4'd1, 4, "n_to_pe");
    one_flit(2, 4'd0, 4'd2, 3, "e_to_w");
    one_flit(4, 4'd1, 4'd3, 1, "pe_to_s");

    e_log.delete();
    drive(24, 5'b11011, 1'b1, 1'b0, 5'b11111);
    chk("rr_thru", e_log.size() >= 18, 1);
    for (int i = 0; i < 17 && i + 1 < e_log.size(); i++)
      chk("rr_order", e_log[i+1], rr_next(int'(e_log[i])));
    drain();

    acc_cnt = 0;
    drive(6, 5'b10000, 1'b1, 1'b0, 5'b11011);
    at_neg();
    chk("bp_ri_low", ri[4], 0);
    chk("bp_accepted", acc_cnt, 3);
    chk("bp_e_so", so[2], 1);
    @(posedge clk);
    #1;
    e_log.delete();
    ro = '1;
    repeat (2) @(posedge clk);
    at_neg();
    chk("bp_burst", e_log.size(), 3);
    chk("bp_ri_back", ri[4], 1);
    drain();

    acc_cnt = 0;
    drive(6, 5'b10000, 1'b1, 1'b0, 5'b11011);
    mon_en = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    at_neg();
    chk("mid_rst_so", so, 0);
    chk("mid_rst_do", dout[0] | dout[1] | dout[2] | dout[3] | dout[4], 0);
    chk("mid_rst_ri", ri, 0);
    chk("mid_rst_pol", polarity, 0);
    reset = 1'b1;
    exq.delete();
    for (int ch = 0; ch < 5; ch++) deliv[ch] = 0;
    ro = '1;
    mon_en = 1'b1;
    at_neg();
    chk("mid_pol1", polarity, 1);
    at_neg();
    chk("mid_pol0", polarity, 0);
    repeat (10) @(posedge clk);
    at_neg();
    chk("mid_no_stale", deliv[0] + deliv[1] + deliv[2] + deliv[3] + deliv[4], 0);

    drive(1500, 5'b11111, 1'b0, 1'b1, 5'b11111);
    drain();

`ifdef CARDINAL_ROUTER_STATS_EN
    for (int j = 0; j < 5; j++) chk("pkt_cnt", pkt_cnt[32*j +: 32], deliv[j]);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
